// File: rtl/shift_bus_scheduler_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// shift_bus_scheduler_if
// Bundle of every signal between the shift-chain scheduler and its two users
// (shift_in = read engine, shift_out = write engine) plus the chain pins.
//
// Handshake: req_X is a level request that the user holds until done_X or
// timeout_err. The scheduler answers with go_X held high until the engine
// signals acceptance by sampling ready_X low; the transfer is complete when
// ready_X is sampled high again. A transfer counts as accepted only on the
// clk edge where go_X=1 and ready_X=0; it counts as finished only on the edge
// where ready_X=1 after acceptance.
//
// Signals
//   action_pulse     tick from the clocker, timeout time base
//   req_read/write   level requests from the users
//   ready_read/write engine idle flags (1 = idle)
//   read/write_shift_clk  engine shift clocks
//   go_read/write    start strobes to the engines
//   shift_clk        chain shift clock
//   n_oe             chain input-buffer enable (active low)
//   owner            00 none, 01 read, 10 write
//   busy             scheduler not idle
//   done_read/write  completion pulses
//   timeout_err      abort pulse
//   state_dbg        raw FSM state for checkers
// -----------------------------------------------------------------------------
interface shift_bus_scheduler_if;
  logic       action_pulse;
  logic       req_read;
  logic       req_write;
  logic       ready_read;
  logic       ready_write;
  logic       read_shift_clk;
  logic       write_shift_clk;
  logic       go_read;
  logic       go_write;
  logic       shift_clk;
  logic       n_oe;
  logic [1:0] owner;
  logic       busy;
  logic       done_read;
  logic       done_write;
  logic       timeout_err;
  logic [2:0] state_dbg;

  // Scheduler side
  modport slave (
    input  action_pulse, req_read, req_write, ready_read, ready_write,
           read_shift_clk, write_shift_clk,
    output go_read, go_write, shift_clk, n_oe, owner, busy,
           done_read, done_write, timeout_err, state_dbg
  );

  // User / engine side
  modport master (
    output action_pulse, req_read, req_write, ready_read, ready_write,
           read_shift_clk, write_shift_clk,
    input  go_read, go_write, shift_clk, n_oe, owner, busy,
           done_read, done_write, timeout_err, state_dbg
  );
endinterface

// File: rtl/shift_bus_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// shift_bus_scheduler
// Shares one external shift chain between the read (shift_in) and write
// (shift_out) engines. Grants level requests round-robin, starts the owner's
// engine through the go/ready handshake, muxes the owner's shift clock onto the
// chain, leaves a guard gap after every transaction and aborts transfers that
// do not finish within TIMEOUT_TICKS action_pulse ticks.
//
// Ports
//   clk      system clock, all state on posedge
//   n_reset  synchronous active-low reset
//   bus      shift_bus_scheduler_if.slave (requests, engine handshake,
//            shift clocks, chain pins, status pulses, state_dbg)
// -----------------------------------------------------------------------------
module shift_bus_scheduler #(
  parameter int TIMEOUT_TICKS = 64,
  parameter int GUARD_CYCLES  = 4,
  parameter bit READ_FIRST    = 1'b1
) (
  input logic                  clk,
  input logic                  n_reset,
  shift_bus_scheduler_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int GRD_W = $clog2(GUARD_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_TICKS);
  localparam logic [GRD_W-1:0] GRD_LAST  = GRD_W'(GUARD_CYCLES - 1);

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_READ  = 2'b01;
  localparam logic [1:0] OWN_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_GO   = 3'd1,
    RD_BUSY = 3'd2,
    WR_GO   = 3'd3,
    WR_BUSY = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             go_read_q, go_read_d;
  logic             go_write_q, go_write_d;
  logic [1:0]       owner_q, owner_d;
  logic             n_oe_q, n_oe_d;
  logic             done_read_q, done_read_d;
  logic             done_write_q, done_write_d;
  logic             timeout_q, timeout_d;
  logic             last_wr_q, last_wr_d;   // 1: write was served last
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GRD_W-1:0] grd_q, grd_d;

  logic [TMO_W-1:0] tmo_inc;
  logic             tmo_hit;
  logic             finish;                 // leave the transaction for GAP

  always_comb begin
    tmo_inc = tmo_q + TMO_W'(bus.action_pulse);
    tmo_hit = (tmo_inc == TMO_LIMIT);
  end

  always_comb begin
    state_d      = state_q;
    go_read_d    = go_read_q;
    go_write_d   = go_write_q;
    owner_d      = owner_q;
    n_oe_d       = n_oe_q;
    done_read_d  = 1'b0;
    done_write_d = 1'b0;
    timeout_d    = 1'b0;
    last_wr_d    = last_wr_q;
    tmo_d        = tmo_q;
    grd_d        = grd_q;
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        // Under contention the side not served last wins.
        if (bus.req_read && (!bus.req_write || last_wr_q)) begin
          state_d   = RD_GO;
          go_read_d = 1'b1;
          owner_d   = OWN_READ;
          n_oe_d    = 1'b0;
          tmo_d     = '0;
        end else if (bus.req_write) begin
          state_d    = WR_GO;
          go_write_d = 1'b1;
          owner_d    = OWN_WRITE;
          tmo_d      = '0;
        end
      end

      // In GO the abort takes priority over a late acceptance so the tick
      // counter can never run past its limit.
      RD_GO: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          timeout_d = 1'b1;
          last_wr_d = 1'b0;
          finish    = 1'b1;
        end else if (!bus.ready_read) begin
          state_d   = RD_BUSY;
          go_read_d = 1'b0;
        end
      end

      // In BUSY a completion seen on the abort edge wins.
      RD_BUSY: begin
        tmo_d = tmo_inc;
        if (bus.ready_read) begin
          done_read_d = 1'b1;
          last_wr_d   = 1'b0;
          finish      = 1'b1;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          last_wr_d = 1'b0;
          finish    = 1'b1;
        end
      end

      WR_GO: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          timeout_d = 1'b1;
          last_wr_d = 1'b1;
          finish    = 1'b1;
        end else if (!bus.ready_write) begin
          state_d    = WR_BUSY;
          go_write_d = 1'b0;
        end
      end

      WR_BUSY: begin
        tmo_d = tmo_inc;
        if (bus.ready_write) begin
          done_write_d = 1'b1;
          last_wr_d    = 1'b1;
          finish       = 1'b1;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          last_wr_d = 1'b1;
          finish    = 1'b1;
        end
      end

      GAP: begin
        grd_d = grd_q + GRD_W'(1);
        if (grd_q == GRD_LAST) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every transaction ends the same way: release the chain and guard it.
    if (finish) begin
      state_d    = GAP;
      go_read_d  = 1'b0;
      go_write_d = 1'b0;
      owner_d    = OWN_NONE;
      n_oe_d     = 1'b1;
      grd_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      go_read_q    <= 1'b0;
      go_write_q   <= 1'b0;
      owner_q      <= OWN_NONE;
      n_oe_q       <= 1'b1;
      done_read_q  <= 1'b0;
      done_write_q <= 1'b0;
      timeout_q    <= 1'b0;
      last_wr_q    <= READ_FIRST;
      tmo_q        <= '0;
      grd_q        <= '0;
    end else begin
      state_q      <= state_d;
      go_read_q    <= go_read_d;
      go_write_q   <= go_write_d;
      owner_q      <= owner_d;
      n_oe_q       <= n_oe_d;
      done_read_q  <= done_read_d;
      done_write_q <= done_write_d;
      timeout_q    <= timeout_d;
      last_wr_q    <= last_wr_d;
      tmo_q        <= tmo_d;
      grd_q        <= grd_d;
    end
  end

  assign bus.go_read     = go_read_q;
  assign bus.go_write    = go_write_q;
  assign bus.owner       = owner_q;
  assign bus.n_oe        = n_oe_q;
  assign bus.done_read   = done_read_q;
  assign bus.done_write  = done_write_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.state_dbg   = state_q;

  // Chain clock comes straight from the owner register so it drops to 0 in
  // the same cycle ownership is released.
  assign bus.shift_clk = (owner_q == OWN_READ)  ? bus.read_shift_clk  :
                         (owner_q == OWN_WRITE) ? bus.write_shift_clk : 1'b0;

endmodule
